// File: rtl/x_buffer_ctrl.sv
// x_buffer_ctrl: sequencing controller for the X operand buffer.
//
// Gates the incoming byte stream into the X buffer until one full tile
// (LOAD_BYTES) is loaded. It then runs NUM_COLS MAC passes over the tile and
// issues one buffer shift between consecutive passes. A done pulse marks the
// end of the frame.
//
// Ports:
//   clk, rst         system clock (rising edge), async active-high reset
//   start            begin a frame (sampled only in IDLE)
//   abort            synchronous abort back to IDLE from any state
//   in_valid         input byte valid
//   in_ready         byte accepted when in_valid is high (same as input_load_en)
//   input_load_en    load enable to the X buffer
//   xload_done       buffer's own last-byte flag, used only for consistency checking
//   x_shift          one-cycle shift command to the X buffer
//   mac_start        one-cycle pulse starting a MAC pass
//   mac_done         MAC pass complete (sampled only in WAIT)
//   busy             high in every state except IDLE
//   done             one-cycle pulse at frame end
//   load_err         sticky load-count mismatch flag, cleared by start or rst
module x_buffer_ctrl #(
  parameter int unsigned LOAD_BYTES = 32,
  parameter int unsigned NUM_COLS   = 8,
  parameter int unsigned CNT_W      = 5,
  parameter int unsigned COL_W      = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  input  logic in_valid,
  output logic in_ready,
  output logic input_load_en,
  input  logic xload_done,
  output logic x_shift,
  output logic mac_start,
  input  logic mac_done,
  output logic busy,
  output logic done,
  output logic load_err
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StMac,
    StWait,
    StShift,
    StDone
  } state_e;

  localparam logic [CNT_W-1:0] LastByte = CNT_W'(LOAD_BYTES - 1);
  localparam logic [COL_W-1:0] LastCol  = COL_W'(NUM_COLS - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [COL_W-1:0]   col_cnt_q, col_cnt_d;
  logic               load_err_q, load_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      col_cnt_q  <= '0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      col_cnt_q  <= col_cnt_d;
      load_err_q <= load_err_d;
    end
  end

  // Next-state logic. Abort overrides everything, including start in IDLE;
  // load_err is left untouched so a mismatch stays visible after an abort.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    col_cnt_d  = col_cnt_q;
    load_err_d = load_err_q;

    if (abort) begin
      state_d    = StIdle;
      byte_cnt_d = '0;
      col_cnt_d  = '0;
    end else begin
      case (state_q)
        StIdle: begin
          byte_cnt_d = '0;
          col_cnt_d  = '0;
          if (start) begin
            state_d    = StLoad;
            load_err_d = 1'b0;
          end
        end
        StLoad: begin
          if (in_valid) begin
            if (byte_cnt_q == LastByte) begin
              byte_cnt_d = '0;
              state_d    = StMac;
              // The buffer must agree that this is its last byte.
              if (!xload_done) begin
                load_err_d = 1'b1;
              end
            end else begin
              byte_cnt_d = byte_cnt_q + 1'b1;
            end
          end
        end
        StMac: begin
          state_d = StWait;
        end
        StWait: begin
          if (mac_done) begin
            state_d = (col_cnt_q == LastCol) ? StDone : StShift;
          end
        end
        StShift: begin
          col_cnt_d = col_cnt_q + 1'b1;
          state_d   = StMac;
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Moore outputs. Load enable and shift come from distinct states, so they
  // can never be high together.
  always_comb begin
    input_load_en = 1'b0;
    x_shift       = 1'b0;
    mac_start     = 1'b0;
    done          = 1'b0;
    busy          = 1'b1;
    case (state_q)
      StIdle:  busy          = 1'b0;
      StLoad:  input_load_en = 1'b1;
      StMac:   mac_start     = 1'b1;
      StShift: x_shift       = 1'b1;
      StDone:  done          = 1'b1;
      default: ;
    endcase
  end

  assign in_ready = input_load_en;
  assign load_err = load_err_q;

endmodule
